game_fsm: RTL and testbench
===========================

Name: game_fsm

Overview:
- Game-control stage directly downstream of the pixel renderer.
- Consumes per-pixel sprite layer bits (dino, cactus/obstacle, asteroid) and the VGA scan address.
- Counts dino/obstacle overlap per frame and runs the IDLE/RUN/DEAD/OVER game state machine.
- Drives game_state, collide (halt) and a one-cycle restart pulse to the movement, score and asteroid blocks, replacing the ad-hoc state and collide logic in the top level.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- HIT_THRESH, 4, overlapping pixels per frame required to declare a collision (must be ≥1)
- DEAD_FRAMES, 60, frames spent in DEAD (death sprite shown) before OVER
- LOCKOUT_FRAMES, 30, frames in OVER during which button presses are ignored
- CNT_W, 8, width of the per-frame hit accumulator

Ports:
- clk  in  1  25 MHz pixel clock (divided_clk domain)
- reset  in  1  synchronous, active-high
- haddress  in  10  current horizontal scan address
- vaddress  in  10  current vertical scan address
- dino_px  in  1  dino layer bit for this address
- obstacle_px  in  1  cactus/overlay layer bit for this address
- asteroid_px  in  1  asteroid layer bit for this address
- leftbtn, rightbtn, upbtn, downbtn  in  1 each  raw asynchronous buttons
- debug  in  1  raw asynchronous force-return switch
- game_state  out  2  0=IDLE, 1=RUN, 2=OVER, 3=DEAD
- collide  out  1  high in DEAD and OVER; halts movement and score
- restart  out  1  one-cycle pulse on IDLE→RUN
- frame_tick  out  1  one-cycle pulse, one cycle after each frame boundary
- hit_count_last  out  CNT_W  overlap count of the last completed frame

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0; game_state = IDLE; accumulator, frame counter, synchronisers and edge registers 0. Reset mid-frame or mid-state takes effect on the next edge. No restart pulse is generated by reset.
- Button input: btn_any = OR of the four buttons. btn_any and debug each pass through a 2-FF synchroniser. press = sync & ~prev.
  - Latency: game_state changes on the 3rd rising edge after btn_any is first sampled high.
- Active area: haddress < H_ACTIVE && vaddress < V_ACTIVE. Pixel bits arrive already aligned with the address presented in the same cycle.
- Overlap: ovl = dino_px & obstacle_px. Outside the active area ovl is ignored.
- Accumulator: acc increments by 1 per active ovl cycle, saturating at 2^CNT_W−1. It counts in every state but is used only in RUN.
- Frame boundary: cycle where vaddress == V_ACTIVE && haddress == 0. On the next edge:
  - hit_count_last <= acc
  - acc <= 0
  - frame_tick = 1 for one cycle
- State machine:
  - IDLE: press → RUN; restart = 1 in the same cycle game_state becomes RUN. collide = 0.
  - RUN: at a frame boundary, if acc ≥ HIT_THRESH → DEAD and collide = 1, both visible the cycle after the boundary. Button presses are ignored. A collision decision and a press in the same cycle resolve to the collision.
  - DEAD: frame counter counts boundaries. After DEAD_FRAMES boundaries → OVER and counter cleared.
  - OVER: counter counts boundaries up to LOCKOUT_FRAMES, then saturates.
    - press with counter == LOCKOUT_FRAMES → IDLE.
    - Synchronised debug high (level) → IDLE regardless of lockout.
    - Presses during lockout are discarded, not queued.
- collide drops to 0 on entry to IDLE.
- The frame counter clears on every state change.

Optional Feature:
- COLLIDE_ASTEROID_EN defined: ovl = dino_px & (obstacle_px | asteroid_px); asteroids kill.
- Undefined: asteroid_px is unused and asteroids are decorative. The port is still present.

Decomposition:
- game_pkg holds:
  - state encoding localparams (ST_IDLE=0, ST_RUN=1, ST_OVER=2, ST_DEAD=3)
  - default H_ACTIVE/V_ACTIVE
- Sub-module btn_edge_sync: 2-FF synchroniser plus rising-edge detector. Instantiated twice, for btn_any and for debug (debug uses only the synchronised level).

Test Plan:
- Reset, then upbtn held high 5 cycles → game_state 0→1 on the 3rd edge, restart high exactly 1 cycle, collide = 0.
- RUN with HIT_THRESH=4: 3 overlap pixels in a frame → no transition, hit_count_last = 3; next frame 4 overlaps → game_state = 3 and collide = 1 one cycle after the boundary.
- DEAD_FRAMES=2: two frame boundaries after DEAD → game_state = 2; frame_tick pulses once per frame.
- OVER, LOCKOUT_FRAMES=2: press after 1 frame → stays 2; press after 2 frames → game_state = 0, collide = 0.
- OVER, debug raised during lockout → game_state = 0 three edges later.
- Overlap at haddress=700 and 300 CNT_W-overflowing pixels (CNT_W=8) → off-screen ignored, hit_count_last = 255.
- With COLLIDE_ASTEROID_EN, dino & asteroid overlap 4 px → DEAD; without it → stays RUN.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings and display defaults for the game-control stage.
package game_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for a raw async input plus rising-edge detect.
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign press = s2 & ~prev;

endmodule

// File: rtl/game_fsm.sv
// Per-frame dino overlap counter and IDLE/RUN/DEAD/OVER game control.
// Define COLLIDE_ASTEROID_EN to make asteroid pixels lethal as well.
module game_fsm
  import game_pkg::*;
#(
  parameter int H_ACTIVE       = H_ACTIVE_DEF,
  parameter int V_ACTIVE       = V_ACTIVE_DEF,
  parameter int HIT_THRESH     = 4,
  parameter int DEAD_FRAMES    = 60,
  parameter int LOCKOUT_FRAMES = 30,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       haddress,
  input  logic [9:0]       vaddress,
  input  logic             dino_px,
  input  logic             obstacle_px,
  input  logic             asteroid_px,
  input  logic             leftbtn,
  input  logic             rightbtn,
  input  logic             upbtn,
  input  logic             downbtn,
  input  logic             debug,
  output logic [1:0]       game_state,
  output logic             collide,
  output logic             restart,
  output logic             frame_tick,
  output logic [CNT_W-1:0] hit_count_last
);

  localparam int FW = $clog2(max2(DEAD_FRAMES, LOCKOUT_FRAMES) + 1) < 1
                    ? 1
                    : $clog2(max2(DEAD_FRAMES, LOCKOUT_FRAMES) + 1);

  localparam logic [9:0]       H_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]       V_LIM     = 10'(V_ACTIVE);
  localparam logic [CNT_W-1:0] THR       = CNT_W'(HIT_THRESH);
  localparam logic [FW-1:0]    DEAD_LAST = FW'(DEAD_FRAMES - 1);
  localparam logic [FW-1:0]    LOCK_MAX  = FW'(LOCKOUT_FRAMES);

  logic             btn_any;
  logic             btn_level_unused;
  logic             press;
  logic             dbg;
  logic             dbg_press_unused;
  logic             active;
  logic             ovl;
  logic             fb;
  logic [CNT_W-1:0] acc;
  logic [FW-1:0]    fcnt;
  logic [FW-1:0]    fcnt_nxt;
  logic [1:0]       state;
  logic [1:0]       state_nxt;

  assign btn_any = leftbtn | rightbtn | upbtn | downbtn;

  btn_edge_sync u_btn (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_any),
    .level (btn_level_unused),
    .press (press)
  );

  btn_edge_sync u_dbg (
    .clk   (clk),
    .reset (reset),
    .raw   (debug),
    .level (dbg),
    .press (dbg_press_unused)
  );

  assign active = (haddress < H_LIM) && (vaddress < V_LIM);
  assign fb     = (vaddress == V_LIM) && (haddress == 10'd0);

`ifdef COLLIDE_ASTEROID_EN
  assign ovl = active & dino_px & (obstacle_px | asteroid_px);
`else
  logic ast_unused;
  assign ast_unused = asteroid_px;
  assign ovl        = active & dino_px & obstacle_px;
`endif

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (press) state_nxt = ST_RUN;
      end
      (state == ST_RUN): begin
        if (fb && acc >= THR) state_nxt = ST_DEAD;
      end
      (state == ST_DEAD): begin
        if (fb) begin
          if (fcnt == DEAD_LAST) state_nxt = ST_OVER;
          else fcnt_nxt = fcnt + 1'b1;
        end
      end
      default: begin
        if (dbg) state_nxt = ST_IDLE;
        else if (press && fcnt == LOCK_MAX) state_nxt = ST_IDLE;
        else if (fb && fcnt < LOCK_MAX) fcnt_nxt = fcnt + 1'b1;
      end
    endcase
    if (state_nxt != state) fcnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      fcnt           <= '0;
      acc            <= '0;
      hit_count_last <= '0;
      frame_tick     <= 1'b0;
      restart        <= 1'b0;
    end else begin
      state      <= state_nxt;
      fcnt       <= fcnt_nxt;
      frame_tick <= fb;
      restart    <= (state == ST_IDLE) && (state_nxt == ST_RUN);
      if (fb) begin
        hit_count_last <= acc;
        acc            <= '0;
      end else if (ovl && acc != '1) begin
        acc <= acc + 1'b1;
      end
    end
  end

  assign game_state = state;
  assign collide    = (state == ST_DEAD) || (state == ST_OVER);

endmodule

// File: tb/tb_game_fsm.sv
// Directed-vector bench for game_fsm with short frame/lockout constants.
module tb_game_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] haddress;
  logic [9:0] vaddress;
  logic       dino_px;
  logic       obstacle_px;
  logic       asteroid_px;
  logic       leftbtn;
  logic       rightbtn;
  logic       upbtn;
  logic       downbtn;
  logic       debug;
  logic [1:0] game_state;
  logic       collide;
  logic       restart;
  logic       frame_tick;
  logic [7:0] hit_count_last;

  int vectors = 0;
  int miscompares = 0;

  game_fsm #(
    .HIT_THRESH     (4),
    .DEAD_FRAMES    (2),
    .LOCKOUT_FRAMES (2),
    .CNT_W          (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .haddress       (haddress),
    .vaddress       (vaddress),
    .dino_px        (dino_px),
    .obstacle_px    (obstacle_px),
    .asteroid_px    (asteroid_px),
    .leftbtn        (leftbtn),
    .rightbtn       (rightbtn),
    .upbtn          (upbtn),
    .downbtn        (downbtn),
    .debug          (debug),
    .game_state     (game_state),
    .collide        (collide),
    .restart        (restart),
    .frame_tick     (frame_tick),
    .hit_count_last (hit_count_last)
  );

  always #20 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ovl_px(input int n, input logic [9:0] h);
    haddress    = h;
    vaddress    = 10'd10;
    dino_px     = 1'b1;
    obstacle_px = 1'b1;
    tick(n);
    dino_px     = 1'b0;
    obstacle_px = 1'b0;
  endtask

  task automatic boundary();
    haddress = 10'd0;
    vaddress = 10'd480;
    tick();
    vaddress = 10'd10;
  endtask

  // press: held 3 edges so the FSM acts on the 3rd, then released and settled
  task automatic press_btn();
    upbtn = 1'b1;
    tick(3);
    upbtn = 1'b0;
    tick(3);
  endtask

  initial begin
    reset = 1'b1;
    haddress = '0; vaddress = 10'd10;
    dino_px = 0; obstacle_px = 0; asteroid_px = 0;
    leftbtn = 0; rightbtn = 0; upbtn = 0; downbtn = 0; debug = 0;
    tick(2);
    chk("rst_state", game_state, 0);
    chk("rst_collide", collide, 0);
    chk("rst_restart", restart, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_hcl", hit_count_last, 0);
    reset = 1'b0;

    upbtn = 1'b1;
    tick();
    chk("start_e1", game_state, 0);
    tick();
    chk("start_e2", game_state, 0);
    chk("start_e2_rst", restart, 0);
    tick();
    chk("start_e3", game_state, 1);
    chk("start_e3_rst", restart, 1);
    chk("start_e3_col", collide, 0);
    tick();
    chk("start_e4_rst", restart, 0);
    tick();
    upbtn = 1'b0;
    tick(3);
    chk("run_hold", game_state, 1);

    ovl_px(3, 10'd100);
    boundary();
    chk("f1_state", game_state, 1);
    chk("f1_hcl", hit_count_last, 3);
    chk("f1_tick", frame_tick, 1);
    tick();
    chk("f1_tick_end", frame_tick, 0);

    ovl_px(4, 10'd100);
    chk("f2_pre", game_state, 1);
    boundary();
    chk("f2_state", game_state, 3);
    chk("f2_col", collide, 1);
    chk("f2_hcl", hit_count_last, 4);
    tick();

    boundary();
    chk("dead1_state", game_state, 3);
    chk("dead1_tick", frame_tick, 1);
    tick();
    chk("dead1_tick_end", frame_tick, 0);
    boundary();
    chk("dead2_state", game_state, 2);
    chk("dead2_col", collide, 1);
    tick();

    boundary();
    tick();
    press_btn();
    chk("lock_press", game_state, 2);
    boundary();
    tick();
    chk("lock_done", game_state, 2);
    upbtn = 1'b1;
    tick(2);
    chk("over_e2", game_state, 2);
    tick();
    chk("over_e3", game_state, 0);
    chk("over_col", collide, 0);
    upbtn = 1'b0;
    tick(3);

    press_btn();
    chk("run2", game_state, 1);
    ovl_px(4, 10'd50);
    boundary();
    boundary();
    boundary();
    tick();
    chk("over2", game_state, 2);
    debug = 1'b1;
    tick(2);
    chk("dbg_e2", game_state, 2);
    tick();
    chk("dbg_e3", game_state, 0);
    debug = 1'b0;
    tick(3);

    press_btn();
    chk("run3", game_state, 1);
    ovl_px(10, 10'd700);
    ovl_px(300, 10'd200);
    boundary();
    chk("sat_hcl", hit_count_last, 255);
    chk("sat_state", game_state, 3);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_state", game_state, 0);
    chk("rst2_restart", restart, 0);
    chk("rst2_hcl", hit_count_last, 0);
    tick();
    press_btn();
    chk("run4", game_state, 1);
    haddress = 10'd20;
    dino_px = 1'b1;
    asteroid_px = 1'b1;
    tick(4);
    dino_px = 1'b0;
    asteroid_px = 1'b0;
    boundary();
`ifdef COLLIDE_ASTEROID_EN
    chk("ast_state", game_state, 3);
    chk("ast_hcl", hit_count_last, 4);
`else
    chk("ast_state", game_state, 1);
    chk("ast_hcl", hit_count_last, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
